// File: rtl/sap1_ctrl_pkg.sv
// Shared definitions for the SAP-1 controller/sequencer:
// opcodes, T-state indices and the control-word layout.
package sap1_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    typedef struct packed {
        logic Cp;
        logic Ep;
        logic Lm_bar;
        logic CE_bar;
        logic Li_bar;
        logic Ei_bar;
        logic La_bar;
        logic Ea;
        logic Su;
        logic Eu;
        logic Lb_bar;
        logic Lo_bar;
    } ctrl_word_t;

    localparam ctrl_word_t CW_IDLE = '{
        Cp:     1'b0,
        Ep:     1'b0,
        Lm_bar: 1'b1,
        CE_bar: 1'b1,
        Li_bar: 1'b1,
        Ei_bar: 1'b1,
        La_bar: 1'b1,
        Ea:     1'b0,
        Su:     1'b0,
        Eu:     1'b0,
        Lb_bar: 1'b1,
        Lo_bar: 1'b1
    };

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

    // Number of W-bus drivers a control word enables at once.
    function automatic logic [2:0] bus_drivers(input ctrl_word_t cw);
        return 3'(cw.Ep) + 3'(!cw.CE_bar) + 3'(!cw.Ei_bar)
             + 3'(cw.Ea) + 3'(cw.Eu);
    endfunction

    function automatic logic op_known(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB)
            || (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot T-state ring: rotates each edge, can hold in place
// or return early to the first state.
module ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             hold_i,
    input  logic             ret_i,
    output logic [NUM_T-1:0] state_o
);

    localparam logic [NUM_T-1:0] FIRST = NUM_T'(1);

    logic [NUM_T-1:0] state_q;
    logic [NUM_T-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (hold_i) begin
            state_d = state_q;
        end else if (ret_i) begin
            state_d = FIRST;
        end else begin
            state_d = {state_q[NUM_T-2:0], state_q[NUM_T-1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: T-state ring plus microinstruction decoder.
// Build option SEQ_VARIABLE_CYCLE_EN skips trailing nop T-states.
module controller_sequencer
    import sap1_ctrl_pkg::*;
#(
    parameter int NUM_T = 6,
    parameter int OP_W  = 4
) (
    input  logic             CLK_bar,
    input  logic             CLR,
    input  logic [OP_W-1:0]  opcode,
    output logic             Cp,
    output logic             Ep,
    output logic             Lm_bar,
    output logic             CE_bar,
    output logic             Li_bar,
    output logic             Ei_bar,
    output logic             La_bar,
    output logic             Ea,
    output logic             Su,
    output logic             Eu,
    output logic             Lb_bar,
    output logic             Lo_bar,
    output logic             HLT,
    output logic [NUM_T-1:0] T_state
);

    mode_t            mode_q;
    logic [NUM_T-1:0] t;
    logic [3:0]       op;
    logic             halted;
    logic             halt_req;
    logic             hold;
    logic             ret;
    ctrl_word_t       cw;
    logic             hlt;

    assign op       = opcode[3:0];
    assign halted   = (mode_q == MODE_HALT);
    assign halt_req = !halted && t[T4] && (op == OP_HLT);
    assign hold     = halted || halt_req;

`ifdef SEQ_VARIABLE_CYCLE_EN
    // Unknown opcodes can only be recognised once the IR is valid in T4.
    assign ret = (t[T5] && (op == OP_LDA))
              || (t[T4] && (op == OP_OUT))
              || (t[T4] && !op_known(op));
`else
    assign ret = 1'b0;
`endif

    ring_counter #(
        .NUM_T (NUM_T)
    ) u_ring (
        .clk_i   (CLK_bar),
        .clr_i   (CLR),
        .hold_i  (hold),
        .ret_i   (ret),
        .state_o (t)
    );

    always_ff @(posedge CLK_bar) begin
        if (CLR) begin
            mode_q <= MODE_RUN;
        end else if (halt_req) begin
            mode_q <= MODE_HALT;
        end
    end

    always_comb begin
        cw  = CW_IDLE;
        hlt = 1'b0;
        if (halted) begin
            hlt = 1'b1;
        end else begin
            unique case (1'b1)
                t[T1]: begin
                    cw.Ep     = 1'b1;
                    cw.Lm_bar = 1'b0;
                end
                t[T2]: begin
                    cw.Cp = 1'b1;
                end
                t[T3]: begin
                    cw.CE_bar = 1'b0;
                    cw.Li_bar = 1'b0;
                end
                t[T4]: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw.Ei_bar = 1'b0;
                            cw.Lm_bar = 1'b0;
                        end
                        OP_OUT: begin
                            cw.Ea     = 1'b1;
                            cw.Lo_bar = 1'b0;
                        end
                        OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                t[T5]: begin
                    case (op)
                        OP_LDA: begin
                            cw.CE_bar = 1'b0;
                            cw.La_bar = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.CE_bar = 1'b0;
                            cw.Lb_bar = 1'b0;
                        end
                        default: ;
                    endcase
                end
                t[T6]: begin
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        cw.Eu     = 1'b1;
                        cw.La_bar = 1'b0;
                        cw.Su     = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assert property (@(posedge CLK_bar) bus_drivers(cw) <= 3'd1);

    assign Cp      = cw.Cp;
    assign Ep      = cw.Ep;
    assign Lm_bar  = cw.Lm_bar;
    assign CE_bar  = cw.CE_bar;
    assign Li_bar  = cw.Li_bar;
    assign Ei_bar  = cw.Ei_bar;
    assign La_bar  = cw.La_bar;
    assign Ea      = cw.Ea;
    assign Su      = cw.Su;
    assign Eu      = cw.Eu;
    assign Lb_bar  = cw.Lb_bar;
    assign Lo_bar  = cw.Lo_bar;
    assign HLT     = hlt;
    assign T_state = t;

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit that drives the SAP-1 datapath: PC (Cp/Ep), MAR, RAM, IR, accumulator, ALU, B and output registers.
- Six-state ring counter (T1..T6) plus a microinstruction decoder.
- Decodes the IR opcode nibble into the control word, one T-state per clock.
- Initiator side of the Cp/Ep handshake to the program counter and of every other bus-load/enable strobe.

Parameters:
- NUM_T, 6, number of T-states in the ring (fixed 6 in the base build).
- OP_W, 4, opcode width (IR upper nibble).

Ports:
- CLK_bar  input  1  system clock; all state updates on its rising edge.
- CLR  input  1  synchronous active-high reset.
- opcode  input  OP_W  IR upper nibble; valid from T4.
- Cp  output  1  PC increment.
- Ep  output  1  PC drives W bus.
- Lm_bar  output  1  MAR load, active-low.
- CE_bar  output  1  RAM drives W bus, active-low.
- Li_bar  output  1  IR load, active-low.
- Ei_bar  output  1  IR operand nibble drives W bus, active-low.
- La_bar  output  1  accumulator load, active-low.
- Ea  output  1  accumulator drives W bus.
- Su  output  1  ALU subtract select.
- Eu  output  1  ALU drives W bus.
- Lb_bar  output  1  B register load, active-low.
- Lo_bar  output  1  output register load, active-low.
- HLT  output  1  halt indication; gates the system clock externally.
- T_state  output  NUM_T  one-hot current T-state; bit0 = T1.

Behaviour:
- State: registered one-hot ring T1→T2→…→T6→T1, advancing on each rising CLK_bar edge unless halted.
- Control word: combinational decode of the registered state and opcode; no extra latency. Inactive levels: active-high strobes 0, _bar strobes 1.
- Reset: CLR=1 at an edge → T_state=000001 (T1), halted=0, regardless of current state (mid-instruction included). Outputs after reset = the T1 word: Ep=1, Lm_bar=0, all others inactive.
- Fetch, identical for every opcode:
  - T1: Ep, Lm_bar.
  - T2: Cp.
  - T3: CE_bar, Li_bar.
- Execute, T4/T5/T6:
  - LDA 0000: Ei_bar+Lm_bar / CE_bar+La_bar / nop.
  - ADD 0001: Ei_bar+Lm_bar / CE_bar+Lb_bar / Eu+La_bar.
  - SUB 0010: as ADD, with Su=1 in T6 only.
  - OUT 1110: Ea+Lo_bar / nop / nop.
  - HLT 1111: T4 asserts HLT; all other controls inactive.
  - Any other opcode: nop in T4-T6; the ring still completes.
- Halt:
  - In T4 with opcode=HLT, the next edge sets halted=1 and the ring holds at T4.
  - While halted: HLT=1 and every other strobe is inactive, independent of later opcode changes.
  - Only CLR exits halt.
- Bus exclusivity: at most one W-bus driver (Ep, CE_bar, Ei_bar, Ea, Eu) active in any state. This is an assertion target.
- Wrap: T6 → T1 with no idle cycle; 6 clocks per instruction in the base build.

Optional Feature:
- Macro: SEQ_VARIABLE_CYCLE_EN.
- Defined: trailing nop states are skipped; the ring returns to T1 after the last useful state.
  - LDA: T5→T1 (5 clocks).
  - OUT: T4→T1 (4 clocks).
  - Undefined opcode: T3→T1 is not permitted because the opcode is unknown until T4, so it ends T4→T1.
  - ADD/SUB: 6 clocks.
  - HLT: unchanged.
- Undefined: fixed 6-clock ring for every opcode.

Decomposition:
- Package sap1_ctrl_pkg:
  - opcode localparams OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT.
  - T-state index constants T1..T6.
  - packed control-word struct ctrl_word_t with field order Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar.
  - CW_IDLE constant (all strobes inactive).
- Sub-module ring_counter: one-hot shifter with hold and early-return inputs and CLR. The decoder stays in controller_sequencer.

Test Plan:
- Reset: CLR=1 for 2 edges from mid-T5 → T_state=000001, Ep=1, Lm_bar=0, HLT=0.
- LDA (opcode=0000), 6 edges:
  - T_state walks 000001…100000 then back to 000001.
  - T2 has only Cp=1; T4 has Ei_bar=0, Lm_bar=0; T5 has CE_bar=0, La_bar=0; T6 is CW_IDLE.
- SUB (opcode=0010): T5 Lb_bar=0; T6 Su=1, Eu=1, La_bar=0. Su=0 in every other state.
- HLT (opcode=1111) at T4:
  - Next 10 edges hold T_state=001000 with HLT=1.
  - Changing opcode to 0001 has no effect.
  - CLR=1 → T1, HLT=0.
- Undefined opcode 0101: T4-T6 all CW_IDLE; the next instruction fetch starts at T1 on edge 6.
- With SEQ_VARIABLE_CYCLE_EN, program OUT, LDA, ADD: T1 entries on edges 0, 4, 9, 15. Throughout, a monitor checks the W-bus driver count ≤ 1 every cycle.
